fifo_burst_reader: RTL and testbench
====================================

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of FIFO read data and stream data.
REQ-002 SHALL have parameter BURST_LEN, default 4, beats per normal burst; legal range 2..255.
REQ-003 SHALL have parameter DRAIN_TIMEOUT, default 16, idle cycles before draining a residual word; legal range 1..255.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-006 SHALL have port fifo_empty_i  input  1  FIFO empty flag.
REQ-007 SHALL have port fifo_almost_empty_i  input  1  FIFO almost-empty flag.
REQ-008 SHALL have port fifo_rdata_i  input  DATA_WIDTH  FIFO head word, valid whenever fifo_empty_i=0 (first-word fall-through).
REQ-009 SHALL have port fifo_rden_o  output  1  FIFO pop strobe.
REQ-010 SHALL have port m_valid_o  output  1  stream data valid.
REQ-011 SHALL have port m_ready_i  input  1  stream consumer ready.
REQ-012 SHALL have port m_data_o  output  DATA_WIDTH  stream data.
REQ-013 SHALL have port m_last_o  output  1  final beat of a burst.
REQ-014 SHALL have port busy_o  output  1  high when FSM is not IDLE or m_valid_o=1.

Function
REQ-015 SHALL implement FSM states IDLE, BURST, DRAIN, state held in a register.
REQ-016 SHALL assert fifo_rden_o combinationally only when state is BURST or DRAIN, fifo_empty_i=0, and (m_valid_o=0 or m_ready_i=1); never when fifo_empty_i=1.
REQ-017 SHALL, on a pop cycle, load fifo_rdata_i into the m_data_o register and set m_valid_o at the next edge (pop-to-valid latency 1 cycle).
REQ-018 SHALL clear m_valid_o at the edge where m_valid_o=1 and m_ready_i=1 and no pop occurs; m_data_o/m_last_o SHALL hold stable while m_valid_o=1 and m_ready_i=0.
REQ-019 SHALL, in IDLE, go to BURST with beat counter cleared when fifo_almost_empty_i=0.
REQ-020 SHALL, in IDLE, count wait cycles while fifo_empty_i=0 and fifo_almost_empty_i=1; counter clears otherwise and on leaving IDLE.
REQ-021 SHALL, in IDLE, go to DRAIN when wait counter equals DRAIN_TIMEOUT-1 and fifo_empty_i=0 and fifo_almost_empty_i=1; REQ-019 takes priority.
REQ-022 SHALL, in BURST, increment an 8-bit beat counter per pop; the pop with counter=BURST_LEN-1 loads m_last_o=1 and returns FSM to IDLE; other pops load m_last_o=0.
REQ-023 SHALL, in BURST with fifo_empty_i=1, stall (no pop, stay in BURST, counter held) until data returns; no timeout applies.
REQ-024 SHALL, in DRAIN, perform exactly one pop with m_last_o=1 then return to IDLE.
REQ-025 SHALL allow back-to-back pops: with m_ready_i=1 continuously, one beat per cycle with no bubble inside a burst.
REQ-026 SHALL insert at least one IDLE cycle between bursts (no pop in the cycle the FSM is in IDLE).

Reset
REQ-027 SHALL, while rst_n=0, force state=IDLE, beat and wait counters=0, m_valid_o=0, m_last_o=0, m_data_o=0, busy_o=0, fifo_rden_o=0, independent of clk.
REQ-028 SHALL, on reset mid-burst, discard the partial burst and any held beat; after release behave as from power-up.

Verification
REQ-029 Bench: FIFO preloaded with 8 words 0x10..0x17, m_ready_i=1 -> two bursts of 4 beats, m_last_o on 0x13 and 0x17, one idle cycle between bursts.
REQ-030 Bench: 1 word 0xAA in FIFO (almost_empty=1), m_ready_i=1 -> no pop for 15 cycles, pop on cycle 16 of waiting, m_valid_o with m_data_o=0xAA, m_last_o=1.
REQ-031 Bench: burst in progress, m_ready_i=0 for 5 cycles after beat 2 -> fifo_rden_o low, m_data_o stable for 5 cycles, burst resumes with beats 3,4 intact.
REQ-032 Bench: FIFO empties after beat 2 of a burst, refilled 10 cycles later -> no underflow pop, burst completes with 4 beats, m_last_o on beat 4.
REQ-033 Bench: rst_n dropped asynchronously mid-burst between clock edges -> m_valid_o, fifo_rden_o, busy_o fall immediately; first burst after release starts at beat 1.
REQ-034 Bench: random m_ready_i, random FIFO fill -> scoreboard shows in-order, no loss or duplication, fifo_rden_o never high with fifo_empty_i=1.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Pops a first-word-fall-through FIFO in fixed-length bursts onto a
// valid/ready stream, draining a lone residual word after an idle timeout.
module fifo_burst_reader #(
  parameter int DATA_WIDTH    = 32,
  parameter int BURST_LEN     = 4,
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty_i,
  input  logic                  fifo_almost_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  fifo_rden_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_DRAIN
  } state_t;

  localparam logic [7:0] LP_BEAT_END = 8'(BURST_LEN - 1);
  localparam logic [7:0] LP_WAIT_END = 8'(DRAIN_TIMEOUT - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_beat;
  logic [7:0]            w_beat_nxt;
  logic [7:0]            r_wait;
  logic [7:0]            w_wait_nxt;
  logic                  r_valid;
  logic                  r_last;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_pop;
  logic                  w_last_beat;

  // A pop needs an empty or departing output slot.
  assign w_pop = (r_state != S_IDLE) && !fifo_empty_i
              && (!r_valid || m_ready_i);

  assign w_last_beat = (r_state == S_DRAIN)
                    || (r_beat == LP_BEAT_END);

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_wait_nxt  = '0;
    unique case (r_state)
      S_IDLE: begin
        w_beat_nxt = '0;
        if (!fifo_almost_empty_i) begin
          w_state_nxt = S_BURST;
        end else if (!fifo_empty_i) begin
          if (r_wait == LP_WAIT_END) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_wait_nxt = r_wait + 8'd1;
          end
        end
      end
      S_BURST: begin
        if (w_pop) begin
          if (r_beat == LP_BEAT_END) begin
            w_state_nxt = S_IDLE;
            w_beat_nxt  = '0;
          end else begin
            w_beat_nxt = r_beat + 8'd1;
          end
        end
      end
      S_DRAIN: begin
        if (w_pop) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_beat_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else if (w_pop) begin
      r_valid <= 1'b1;
      r_last  <= w_last_beat;
      r_data  <= fifo_rdata_i;
    end else if (r_valid && m_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign fifo_rden_o = w_pop;
  assign m_valid_o   = r_valid;
  assign m_data_o    = r_data;
  assign m_last_o    = r_last;
  assign busy_o      = (r_state != S_IDLE) || r_valid;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FWFT FIFO model, stream monitor,
// preload vector table, directed corner sequences and a random run.
module tb_fifo_burst_reader;

  localparam int DW = 32;
  localparam int BL = 4;
  localparam int DT = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_empty;
  logic          fifo_ae;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rden;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;

  logic [DW-1:0] mem [256];
  int wp = 0;
  int rp = 0;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int viol = 0;

  logic [DW-1:0] q_data [$];
  bit            q_last [$];
  int            q_cyc  [$];
  int            pop_cyc [$];

  typedef struct {
    int            nwords;
    logic [DW-1:0] base;
    int            exp_beats;
    int            exp_lasts;
  } vec_t;

  fifo_burst_reader #(
    .DATA_WIDTH   (DW),
    .BURST_LEN    (BL),
    .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .fifo_empty_i       (fifo_empty),
    .fifo_almost_empty_i(fifo_ae),
    .fifo_rdata_i       (fifo_rdata),
    .fifo_rden_o        (fifo_rden),
    .m_valid_o          (m_valid),
    .m_ready_i          (m_ready),
    .m_data_o           (m_data),
    .m_last_o           (m_last),
    .busy_o             (busy)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wp == rp);
  assign fifo_ae    = ((wp - rp) <= 1);
  assign fifo_rdata = mem[rp[7:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rden) rp <= rp + 1;
  end

  // Sample just before each rising edge.
  always @(negedge clk) begin
    #4;
    if (rst_n) begin
      if (fifo_rden && fifo_empty) viol++;
      if (fifo_rden) pop_cyc.push_back(cyc);
      if (m_valid && m_ready) begin
        q_data.push_back(m_data);
        q_last.push_back(m_last);
        q_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(logic [DW-1:0] v);
    mem[wp[7:0]] = v;
    wp = wp + 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    m_ready = 1'b1;
    wp      = rp;
    repeat (2) @(negedge clk);
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
    pop_cyc.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_beats(int n, int budget, string name);
    int k = 0;
    while (q_data.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(q_data.size() >= n), 32'd1);
  endtask

  initial begin
    vec_t vt [7];
    int   p0;
    int   bad;
    int   lasts;
    int   len;
    int   pushed;
    bit   el;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst_n   = 1'b0;
    m_ready = 1'b1;
    #1;
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_rden",  32'(fifo_rden), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_last",  32'(m_last), 32'd0);
    check("rst_data",  m_data, 32'd0);

    vt[0] = '{0, 32'h100, 0, 0};
    vt[1] = '{1, 32'h200, 1, 1};
    vt[2] = '{2, 32'h300, 2, 0};
    vt[3] = '{3, 32'h400, 3, 0};
    vt[4] = '{4, 32'h500, 4, 1};
    vt[5] = '{5, 32'h600, 5, 2};
    vt[6] = '{8, 32'h700, 8, 2};

    for (int v = 0; v < 7; v++) begin
      do_reset();
      for (int i = 0; i < vt[v].nwords; i++) push(vt[v].base + DW'(i));
      repeat (60) @(negedge clk);
      check($sformatf("vec%0d_beats", v), 32'(q_data.size()),
            32'(vt[v].exp_beats));
      lasts = 0;
      bad   = 0;
      for (int i = 0; i < q_data.size(); i++) begin
        if (q_last[i]) lasts++;
        if (q_data[i] !== vt[v].base + DW'(i)) bad++;
        el = (i % BL == BL - 1)
          || (vt[v].nwords % BL == 1 && i == vt[v].nwords - 1);
        if (q_last[i] != el) bad++;
      end
      check($sformatf("vec%0d_lasts", v), 32'(lasts), 32'(vt[v].exp_lasts));
      check($sformatf("vec%0d_order", v), 32'(bad), 32'd0);
    end

    // Two back-to-back bursts of preloaded data
    do_reset();
    p0 = cyc;
    for (int i = 0; i < 8; i++) push(32'h10 + DW'(i));
    wait_beats(8, 40, "b2b_done");
    check("b2b_first_pop", 32'(pop_cyc[0] - p0), 32'd1);
    check("b2b_pop_to_vld", 32'(q_cyc[0] - pop_cyc[0]), 32'd1);
    check("b2b_no_bubble", 32'(pop_cyc[3] - pop_cyc[0]), 32'd3);
    check("b2b_idle_gap", 32'(pop_cyc[4] - pop_cyc[3]), 32'd2);
    check("b2b_d3", q_data[3], 32'h13);
    check("b2b_l3", 32'(q_last[3]), 32'd1);
    check("b2b_l2", 32'(q_last[2]), 32'd0);
    check("b2b_d7", q_data[7], 32'h17);
    check("b2b_l7", 32'(q_last[7]), 32'd1);

    // Lone word drained after the idle timeout
    do_reset();
    p0 = cyc;
    push(32'hAA);
    wait_beats(1, 40, "drain_done");
    check("drain_pops", 32'(pop_cyc.size()), 32'd1);
    check("drain_pop_cyc", 32'(pop_cyc[0] - p0), 32'(DT));
    check("drain_data", q_data[0], 32'hAA);
    check("drain_last", 32'(q_last[0]), 32'd1);

    // Backpressure holds the third beat
    do_reset();
    for (int i = 0; i < 4; i++) push(32'h30 + DW'(i));
    wait_beats(2, 20, "bp_two");
    m_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #4;
      if (fifo_rden !== 1'b0) bad++;
      if (m_valid !== 1'b1) bad++;
      if (m_data !== 32'h32) bad++;
      @(negedge clk);
    end
    check("bp_hold", 32'(bad), 32'd0);
    check("bp_no_xfer", 32'(q_data.size()), 32'd2);
    m_ready = 1'b1;
    wait_beats(4, 20, "bp_done");
    check("bp_d2", q_data[2], 32'h32);
    check("bp_d3", q_data[3], 32'h33);
    check("bp_l3", 32'(q_last[3]), 32'd1);

    // FIFO runs dry mid-burst, then refills
    do_reset();
    push(32'h20);
    push(32'h21);
    wait_beats(2, 20, "dry_two");
    repeat (10) @(negedge clk);
    check("dry_pops", 32'(pop_cyc.size()), 32'd2);
    check("dry_valid", 32'(m_valid), 32'd0);
    check("dry_busy", 32'(busy), 32'd1);
    push(32'h22);
    push(32'h23);
    wait_beats(4, 20, "dry_done");
    check("dry_d3", q_data[3], 32'h23);
    check("dry_l3", 32'(q_last[3]), 32'd1);
    check("dry_l1", 32'(q_last[1]), 32'd0);

    // Asynchronous reset in the middle of a burst
    do_reset();
    for (int i = 0; i < 8; i++) push(32'h50 + DW'(i));
    wait_beats(2, 20, "ar_two");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(m_valid), 32'd0);
    check("ar_rden", 32'(fifo_rden), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_data", m_data, 32'd0);
    @(negedge clk);
    wp = rp;
    repeat (2) @(negedge clk);
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
    pop_cyc.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h60 + DW'(i));
    wait_beats(4, 20, "ar_done");
    check("ar_d0", q_data[0], 32'h60);
    check("ar_l2", 32'(q_last[2]), 32'd0);
    check("ar_l3", 32'(q_last[3]), 32'd1);

    // Random ready and random fill against an in-order scoreboard
    do_reset();
    pushed = 0;
    for (int c = 0; c < 6000 && q_data.size() < 200; c++) begin
      int k;
      @(negedge clk);
      m_ready = ($urandom_range(0, 9) < 7);
      k = int'($urandom_range(0, 7));
      if ((wp - rp) < 64 && k < 2) begin
        push(32'h1000 + DW'(pushed));
        pushed++;
        if (k == 0) begin
          push(32'h1000 + DW'(pushed));
          pushed++;
        end
      end
    end
    m_ready = 1'b1;
    check("rnd_count", 32'(q_data.size() >= 200), 32'd1);
    bad   = 0;
    lasts = 0;
    len   = 0;
    for (int i = 0; i < q_data.size(); i++) begin
      if (q_data[i] !== 32'h1000 + DW'(i)) bad++;
      len++;
      if (q_last[i]) begin
        lasts++;
        if (len != 1 && len != BL) bad++;
        len = 0;
      end
    end
    check("rnd_order", 32'(bad), 32'd0);
    check("rnd_has_last", 32'(lasts > 0), 32'd1);
    check("no_underflow", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
